// File: rtl/pixel_word_packer_pkg.sv
// Shared imager definitions for the pixel word packer.
package pixel_word_packer_pkg;

  localparam int unsigned PIXELS_PER_WORD = 4;
  localparam int unsigned LANE_W          = 2;
  localparam int unsigned STAGE_LANES     = PIXELS_PER_WORD - 1;
  localparam int unsigned PIXEL_W         = 8;
  localparam int unsigned WORD_W          = PIXELS_PER_WORD * PIXEL_W;

  typedef logic [LANE_W-1:0] lane_idx_t;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } packer_state_e;

  localparam logic [PIXEL_W-1:0] PAD_BYTE_DEFAULT = 8'h00;

endpackage

// File: rtl/pixel_word_packer.sv
// Packs 8-bit pixels into 32-bit FIFO words with one-word backpressure
// buffering, padded frame-end flush and drop accounting.
module pixel_word_packer
  import pixel_word_packer_pkg::*;
#(
  parameter logic [7:0]  PAD_BYTE = PAD_BYTE_DEFAULT,
  parameter int unsigned DROP_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              pixel_valid,
  input  logic [7:0]        pixel_data,
  input  logic              frame_done,
  input  logic              fifo_full,
  output logic              word_valid,
  output logic [31:0]       word_data,
  output logic              word_last,
  output logic              frame_flushed,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  localparam lane_idx_t LANE_MAX = lane_idx_t'(PIXELS_PER_WORD - 1);

  packer_state_e                         state_q, state_d;
  lane_idx_t                             cnt_q, cnt_d;
  logic [STAGE_LANES-1:0][PIXEL_W-1:0]   stage_q, stage_d;
  logic                                  pend_valid_q, pend_valid_d;
  logic [WORD_W-1:0]                     pend_data_q, pend_data_d;
  logic                                  pend_last_q, pend_last_d;
  logic                                  word_valid_q;
  logic [WORD_W-1:0]                     word_data_q;
  logic                                  word_last_q;
  logic                                  frame_flushed_q;
  logic                                  overflow_q;
  logic [DROP_W-1:0]                     drop_count_q;

  logic              new_valid, new_last, tag_pend, empty_done, drop_hit;
  logic [WORD_W-1:0] new_data, pad_word;
  logic              emit, emit_last;
  logic [WORD_W-1:0] emit_data;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stage_d      = stage_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_last_d  = pend_last_q;
    new_valid    = 1'b0;
    new_last     = 1'b0;
    new_data     = '0;
    pad_word     = {PIXELS_PER_WORD{PAD_BYTE}};
    tag_pend     = 1'b0;
    empty_done   = 1'b0;
    drop_hit     = 1'b0;
    emit         = 1'b0;
    emit_last    = 1'b0;
    emit_data    = word_data_q;

    // Stage the byte first; a same-cycle frame_done then flushes the result.
    if (state_q == ACCUM) begin
      if (pixel_valid) begin
        if (cnt_q == LANE_MAX) begin
          new_valid = 1'b1;
          new_data  = {pixel_data, stage_q};
          cnt_d     = '0;
        end else begin
          for (int unsigned i = 0; i < STAGE_LANES; i++) begin
            if (cnt_q == lane_idx_t'(i)) stage_d[i] = pixel_data;
          end
          cnt_d = cnt_q + lane_idx_t'(1);
        end
      end
      for (int unsigned i = 0; i < STAGE_LANES; i++) begin
        if (i < 32'(cnt_d)) pad_word[i*PIXEL_W +: PIXEL_W] = stage_d[i];
      end
      if (frame_done) begin
        if (cnt_d != '0) begin
          new_valid = 1'b1;
          new_last  = 1'b1;
          new_data  = pad_word;
          cnt_d     = '0;
        end else if (new_valid) begin
          new_last = 1'b1;
        end else if (pend_valid_q) begin
          tag_pend = 1'b1;
        end else begin
          empty_done = 1'b1;
        end
      end
    end else if (pixel_valid) begin
      // Pixels are discarded while flushing; only whole lost words count.
      cnt_d = cnt_q + lane_idx_t'(1);
      if (cnt_q == LANE_MAX) drop_hit = 1'b1;
    end

    if (pend_valid_q) begin
      if (!fifo_full) begin
        emit         = 1'b1;
        emit_data    = pend_data_q;
        emit_last    = pend_last_q | tag_pend;
        pend_valid_d = new_valid;
        pend_data_d  = new_data;
        pend_last_d  = new_last;
      end else begin
        pend_last_d = pend_last_q | tag_pend;
        // A dropped last word hands its frame-end tag to the held word.
        if (new_valid) begin
          drop_hit    = 1'b1;
          pend_last_d = pend_last_d | new_last;
        end
      end
    end else if (new_valid) begin
      if (!fifo_full) begin
        emit      = 1'b1;
        emit_data = new_data;
        emit_last = new_last;
      end else begin
        pend_valid_d = 1'b1;
        pend_data_d  = new_data;
        pend_last_d  = new_last;
      end
    end

    state_d = (pend_valid_d && pend_last_d) ? FLUSH : ACCUM;
    if (state_q == FLUSH && emit_last) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ACCUM;
      cnt_q           <= '0;
      stage_q         <= '0;
      pend_valid_q    <= 1'b0;
      pend_data_q     <= '0;
      pend_last_q     <= 1'b0;
      word_valid_q    <= 1'b0;
      word_data_q     <= '0;
      word_last_q     <= 1'b0;
      frame_flushed_q <= 1'b0;
      overflow_q      <= 1'b0;
      drop_count_q    <= '0;
    end else if (clear) begin
      state_q         <= ACCUM;
      cnt_q           <= '0;
      stage_q         <= '0;
      pend_valid_q    <= 1'b0;
      pend_data_q     <= '0;
      pend_last_q     <= 1'b0;
      word_valid_q    <= 1'b0;
      word_data_q     <= '0;
      word_last_q     <= 1'b0;
      frame_flushed_q <= 1'b0;
      overflow_q      <= 1'b0;
      drop_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      stage_q         <= stage_d;
      pend_valid_q    <= pend_valid_d;
      pend_data_q     <= pend_data_d;
      pend_last_q     <= pend_last_d;
      word_valid_q    <= emit;
      word_last_q     <= emit & emit_last;
      frame_flushed_q <= empty_done | (emit & emit_last);
      if (emit) word_data_q <= emit_data;
      if (drop_hit) begin
        overflow_q <= 1'b1;
        if (drop_count_q != '1) drop_count_q <= drop_count_q + DROP_W'(1);
      end
    end
  end

  assign word_valid    = word_valid_q;
  assign word_data     = word_data_q;
  assign word_last     = word_last_q;
  assign frame_flushed = frame_flushed_q;
  assign overflow      = overflow_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_pixel_word_packer.sv
// Scoreboard bench for pixel_word_packer: expected words queued at stimulus,
// popped and compared whenever the DUT writes a word.
module tb_pixel_word_packer;

  localparam int unsigned TB_DROP_W = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 clear = 1'b0;
  logic                 pixel_valid = 1'b0;
  logic [7:0]           pixel_data = '0;
  logic                 frame_done = 1'b0;
  logic                 fifo_full = 1'b0;
  logic                 word_valid;
  logic [31:0]          word_data;
  logic                 word_last;
  logic                 frame_flushed;
  logic                 overflow;
  logic [TB_DROP_W-1:0] drop_count;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_word_t;

  exp_word_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int flush_seen = 0;
  int exp_flush  = 0;
  logic full_q = 1'b0;

  pixel_word_packer #(.DROP_W(TB_DROP_W)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .frame_done(frame_done), .fifo_full(fifo_full),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
    .frame_flushed(frame_flushed), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_word(input logic [31:0] d, input logic l);
    exp_word_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endfunction

  always @(posedge clk) full_q <= fifo_full;

  // Output monitor: every FIFO write must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_flushed) flush_seen++;
      if (word_valid) begin
        check("no_write_when_full", 64'(full_q), 64'(0));
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(word_data), 64'hdead_0000_0000);
        end else begin
          exp_word_t e;
          e = exp_q.pop_front();
          check("word_data", 64'(word_data), 64'(e.data));
          check("word_last", 64'(word_last), 64'(e.last));
          check("flushed_with_last", 64'(frame_flushed), 64'(e.last));
        end
      end
    end
  end

  task automatic step(input logic pv, input logic [7:0] pd, input logic fd);
    pixel_valid = pv;
    pixel_data  = pd;
    frame_done  = fd;
    @(posedge clk); #1;
    pixel_valid = 1'b0;
    frame_done  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic soft_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic drained(input string tag);
    idle(4);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_flush_count"}, 64'(flush_seen), 64'(exp_flush));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_word_valid", 64'(word_valid), 64'(0));
    check("rst_word_data", 64'(word_data), 64'(0));
    check("rst_word_last", 64'(word_last), 64'(0));
    check("rst_frame_flushed", 64'(frame_flushed), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_drop_count", 64'(drop_count), 64'(0));
    reset = 1'b0;
    idle(2);

    // Basic packing and one-cycle latency.
    push_word(32'h44332211, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    check("t1_latency", 64'(word_valid), 64'(1));
    drained("t1");

    // Padded partial word at frame end.
    push_word(32'h04030201, 1'b0);
    push_word(32'h00000605, 1'b1);
    exp_flush++;
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("t2_flush_latency", 64'(word_valid & word_last), 64'(1));
    drained("t2");

    // Backpressure: one word held, two dropped.
    fifo_full = 1'b1;
    push_word(32'h24232221, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h21 + i), 1'b0);
    idle(2);
    fifo_full = 1'b0;
    drained("t3");
    check("t3_overflow", 64'(overflow), 64'(1));
    check("t3_drop_count", 64'(drop_count), 64'(2));

    // Fourth pixel coincident with frame_done.
    push_word(32'h54535251, 1'b1);
    exp_flush++;
    step(1'b1, 8'h51, 1'b0);
    step(1'b1, 8'h52, 1'b0);
    step(1'b1, 8'h53, 1'b0);
    step(1'b1, 8'h54, 1'b1);
    drained("t4");

    // Clear discards staged bytes and zeroes drop accounting.
    step(1'b1, 8'h91, 1'b0);
    step(1'b1, 8'h92, 1'b0);
    soft_clear();
    check("t5_overflow_cleared", 64'(overflow), 64'(0));
    check("t5_drop_cleared", 64'(drop_count), 64'(0));
    idle(2);
    push_word(32'hA3A2A1A0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
    drained("t5");

    // frame_done with nothing outstanding: flush pulse only.
    exp_flush++;
    step(1'b0, 8'h00, 1'b1);
    check("t6_empty_flush", 64'(frame_flushed), 64'(1));
    check("t6_no_word", 64'(word_valid), 64'(0));
    drained("t6");

    // Last word held under backpressure; pixels during flush are dropped.
    fifo_full = 1'b1;
    push_word(32'h0000B2B1, 1'b1);
    exp_flush++;
    step(1'b1, 8'hB1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hE0 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("t7_drop_in_flush", 64'(drop_count), 64'(1));
    check("t7_overflow", 64'(overflow), 64'(1));
    fifo_full = 1'b0;
    drained("t7");
    push_word(32'hC3C2C1C0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    drained("t7b");

    // Drop counter saturates at all-ones.
    soft_clear();
    fifo_full = 1'b1;
    push_word(32'h03020100, 1'b0);
    for (int i = 0; i < 72; i++) step(1'b1, 8'(i), 1'b0);
    check("t8_drop_saturated", 64'(drop_count), 64'(15));
    check("t8_overflow", 64'(overflow), 64'(1));
    fifo_full = 1'b0;
    drained("t8");

    // Async reset while a word is pending.
    fifo_full = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hD0 + i), 1'b0);
    check("t9_pre_overflow", 64'(overflow), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    check("t9_async_word_valid", 64'(word_valid), 64'(0));
    check("t9_async_word_data", 64'(word_data), 64'(0));
    check("t9_async_word_last", 64'(word_last), 64'(0));
    check("t9_async_flushed", 64'(frame_flushed), 64'(0));
    check("t9_async_overflow", 64'(overflow), 64'(0));
    check("t9_async_drop", 64'(drop_count), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    fifo_full = 1'b0;
    drained("t9");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_word_packer.md
# pixel_word_packer

Packs the 8-bit pixel stream from the serial ADC controller into 32-bit words for the pixel FIFO, one camera channel per instance. Sits between the ADC controller's write strobe/data and the FIFO write port inside the imager subsystem. It holds one word back when the FIFO is full and flushes a padded partial word at frame end. It also reports drops and frame-flush completion so the APB side can raise an interrupt only after every pixel of a frame is in the FIFO.

## Interface
- PAD_BYTE, 8'h00, value written into unused byte lanes of a flushed partial word
- DROP_W, 16, width of the saturating dropped-word counter
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- clear  in  1  synchronous per-camera soft reset (cam reset from APB); same effect as reset, one cycle
- pixel_valid  in  1  one-cycle strobe, pixel_data valid
- pixel_data  in  8  pixel sample
- frame_done  in  1  one-cycle pulse, last pixel of frame already strobed (or strobed same cycle)
- fifo_full  in  1  FIFO full status
- word_valid  out  1  FIFO write enable, one cycle per word
- word_data  out  32  word; first pixel in [7:0], fourth in [31:24]
- word_last  out  1  high with word_valid on final word of a frame
- frame_flushed  out  1  one-cycle pulse, all frame data written
- overflow  out  1  sticky, a word was dropped; cleared only by reset/clear
- drop_count  out  DROP_W  saturating count of dropped words

## Operation
- Staging register (3 bytes) + lane counter 0..3. Each pixel_valid writes pixel_data into lane[cnt], cnt increments.
- On the 4th byte, the word is complete: {pixel_data, stage[2], stage[1], stage[0]}; cnt wraps to 0.
- One-entry pending register. A completed word goes to the output if fifo_full=0 and nothing is pending, otherwise into pending.
- Pending drains on the first cycle with fifo_full=0. Pending words always emit before newer words.
- A word completes while pending is occupied and fifo_full=1: the new word is dropped. overflow<=1. drop_count increments, saturating at all-ones.
- frame_done: if cnt>0, the partial word is completed with PAD_BYTE in the unused lanes and tagged last. If cnt=0, the most recent word (pending, or completing this cycle) is tagged last. If no word is outstanding, no word is emitted and frame_flushed pulses next cycle.
- pixel_valid and frame_done in the same cycle: the byte is staged first, then the flush applies to the result.
- States:
  - ACCUM: normal packing.
  - FLUSH: a last-tagged word is awaiting FIFO space. pixel_valid is ignored and counted as a drop only when a full word would have completed. Exit to ACCUM on emitting the last word, pulsing frame_flushed the same cycle as word_valid&word_last.
- frame_done while in FLUSH is ignored.
- clear mid-word: staged bytes and pending word are discarded. No word_valid is emitted. overflow and drop_count are zeroed.

## Timing
- Reset values: word_valid=0, word_data=0, word_last=0, frame_flushed=0, overflow=0, drop_count=0, cnt=0, state ACCUM.
- Latency: word_valid is registered, one cycle after the 4th pixel_valid when fifo_full=0.
- Pending drain: word_valid is asserted the cycle after fifo_full is sampled low.
- Flush latency: one cycle after frame_done when the FIFO is not full.
- Max sustained input: one pixel per cycle.
- word_valid is never asserted in a cycle where fifo_full was sampled high on the preceding edge.

## Structure
- The shared imager package holds:
  - PIXELS_PER_WORD=4
  - the lane index typedef (2 bits)
  - the packer state enum (ACCUM, FLUSH)
  - the default PAD_BYTE constant
- No sub-module. Staging, pending, and FSM are in one module, ~150–200 lines.
- One instance per camera, fed by the ADC controller write strobe/data; outputs go to the pixel FIFO write side.

## Test plan
- Pixels 0x11,0x22,0x33,0x44, fifo_full=0 -> one word_valid, word_data=0x44332211, word_last=0.
- 6 pixels 0x01..0x06 then frame_done, PAD_BYTE=0x00 -> words 0x04030201 then 0x00000605 with word_last=1. frame_flushed pulses with the second word.
- fifo_full=1 across 12 pixels, then released -> first word emitted after release, second and third dropped. overflow=1, drop_count=2.
- 4th pixel and frame_done in the same cycle -> single word, word_last=1, no pad word.
- 2 pixels staged, then clear -> no word_valid. Next 4 pixels 0xA0..0xA3 -> 0xA3A2A1A0.
- Async reset asserted while pending word held -> all outputs 0 immediately. No word emitted after deassert.
